register_file_mp: RTL
=====================

# register_file_mp

Parametrised multi-port integer register file with a per-register scoreboard. It serves as the next-generation register file for the pipelined and dual-issue cores. Read and write port counts, data width and depth are configurable, and same-cycle write-to-read bypass is optional. Register 0 is hardwired to zero, and a busy bit per register tracks outstanding producers for hazard detection.

## Interface
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, register address width
- REG_DEPTH, 32, number of registers; must be ≤ 2**ADDR_WIDTH
- NUM_RD, 2, read port count (≥1)
- NUM_WR, 1, write port count (≥1)
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return stored value only
- i_clk  in  1  clock; all state updates on rising edge
- i_arst  in  1  reset, asynchronous, active-high
- i_rd_addr  in  NUM_RD×ADDR_WIDTH  read addresses
- o_rd_data  out  NUM_RD×DATA_WIDTH  read data
- o_rd_busy  out  NUM_RD  busy bit of the addressed register
- i_wr_en  in  NUM_WR  write enables
- i_wr_addr  in  NUM_WR×ADDR_WIDTH  write addresses
- i_wr_data  in  NUM_WR×DATA_WIDTH  write data
- i_rsv_en  in  1  reserve (mark busy) request
- i_rsv_addr  in  ADDR_WIDTH  register to reserve
- o_wr_conflict  out  1  two or more enabled writes target the same nonzero register this cycle

## Operation
- On reset, all registers are 0 and all busy bits are 0. Outputs then follow combinationally: o_rd_data = 0, o_rd_busy = 0, and o_wr_conflict = 0 unless inputs conflict.
- Register 0:
  - Writes to it are discarded.
  - Reserving it is ignored.
  - A read of it always returns 0 with busy = 0, in both BYPASS modes.
- Write conflict: when several enabled ports hit the same register, the highest-index port wins. o_wr_conflict asserts in the same cycle as an indication only.
- Reads are combinational from array state.
  - BYPASS=1: if an enabled write targets the read address this cycle, o_rd_data returns the winning write data and o_rd_busy = 0.
  - BYPASS=0: the stored value and the stored busy bit are returned.
- Addresses ≥ REG_DEPTH:
  - Reads return 0 and busy = 0.
  - Writes and reserves are ignored.
- Scoreboard, evaluated per register each edge:
  - Reserve only: busy ← 1.
  - Enabled write only: busy ← 0.
  - Reserve and write to the same register in the same cycle: data is written and busy ← 1. The reserve marks a new producer, so it wins.
  - Neither: busy is held.
- A write to a non-busy register is legal; busy stays 0.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge: data is visible from stored state in the next cycle.
- A busy set or clear takes effect at the edge. With BYPASS=1, a same-cycle write already masks busy.
- Reset asserted mid-operation clears all state immediately, with no clock needed. Writes presented during reset are lost.
- There is no handshake. Every enabled write is accepted unconditionally, and the caller must avoid losing conflicting writes.

## Structure
- Package regfile_pkg holds:
  - Default parameter constants.
  - ZERO_REG = 0.
  - Typedefs reg_addr_t and reg_data_t for the default widths.
- Sub-module regfile_wr_select performs per-register write selection. It is a priority encoder over NUM_WR ports producing a hit flag and selected data. It is instantiated once per register and reused by the bypass path with the read address.
- Storage is one always_ff with async reset. The busy vector is a separate REG_DEPTH-bit register.

## Test plan
- Reset, write 0xDEAD_BEEF to x5, deassert enable, read port0 = x5 next cycle -> 0xDEAD_BEEF. Assert i_arst without a clock -> reads return 0 immediately.
- Write 0x1234 to x0 -> read x0 = 0 in both BYPASS settings. Reserve x0 -> busy stays 0.
- NUM_WR=2: port0 writes x7 = 0x11 and port1 writes x7 = 0x22 in the same cycle -> o_wr_conflict = 1 that cycle; x7 = 0x22 afterwards.
- BYPASS=1: write x3 = 0xAA while reading x3 in the same cycle -> o_rd_data = 0xAA, busy = 0. With BYPASS=0, the same stimulus returns the old value that cycle.
- Sequence on x9:
  - Reserve x9 -> busy = 1 next cycle.
  - Write x9 = 0x55 -> busy = 0 next cycle.
  - Reserve and write x9 together -> data = new value, busy = 1.
- Read address REG_DEPTH (32 when ADDR_WIDTH=6) -> data 0, busy 0. A write to that address does not alter any in-range register.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file with scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_REG_DEPTH  = 32;
    localparam int DEF_NUM_RD     = 2;
    localparam int DEF_NUM_WR     = 1;
    localparam int DEF_BYPASS     = 1;
    localparam int ZERO_REG       = 0;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wr_select.sv
// Priority write selector: finds the highest-index enabled write port hitting match_addr_i.
module regfile_wr_select #(
    parameter int NUM_WR     = 1,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0]        match_addr_i,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
    output logic                         hit_o,
    output logic [DATA_WIDTH-1:0]        data_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        // Later iterations override earlier ones, so the highest port wins.
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en_i[i] && wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == match_addr_i) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with zero register, optional write bypass and busy scoreboard.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_DEPTH  = DEF_REG_DEPTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int BYPASS     = DEF_BYPASS
) (
    input  logic                         i_clk,
    input  logic                         i_arst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rd_data,
    output logic [NUM_RD-1:0]            o_rd_busy,
    input  logic [NUM_WR-1:0]            i_wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data,
    input  logic                         i_rsv_en,
    input  logic [ADDR_WIDTH-1:0]        i_rsv_addr,
    output logic                         o_wr_conflict
);

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(REG_DEPTH);

    logic [DATA_WIDTH-1:0] regs_q [REG_DEPTH];
    logic [REG_DEPTH-1:0]  busy_q;
    logic [REG_DEPTH-1:0]  busy_d;
    logic [REG_DEPTH-1:0]  wr_hit;
    logic [DATA_WIDTH-1:0] wr_sel_data [REG_DEPTH];
    logic                  wr_conflict;

    genvar r;
    for (r = 0; r < REG_DEPTH; r++) begin : g_reg
        regfile_wr_select #(
            .NUM_WR    (NUM_WR),
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_sel (
            .match_addr_i(ADDR_WIDTH'(r)),
            .wr_en_i     (i_wr_en),
            .wr_addr_i   (i_wr_addr),
            .wr_data_i   (i_wr_data),
            .hit_o       (wr_hit[r]),
            .data_o      (wr_sel_data[r])
        );
    end

    // NOTE: the storage array is reset explicitly so reads are zero from reset onward.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int k = 0; k < REG_DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < REG_DEPTH; k++) begin
                if (k != ZERO_REG && wr_hit[k]) begin
                    regs_q[k] <= wr_sel_data[k];
                end
            end
        end
    end

    // A reserve marks a new producer, so it overrides a same-cycle write's clear.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < REG_DEPTH; k++) begin
            if (k != ZERO_REG) begin
                if (wr_hit[k]) begin
                    busy_d[k] = 1'b0;
                end
                if (i_rsv_en && i_rsv_addr == ADDR_WIDTH'(k)) begin
                    busy_d[k] = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        wr_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (i_wr_en[i] && i_wr_en[j]
                    && i_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == i_wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]
                    && i_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0
                    && {1'b0, i_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_EXT) begin
                    wr_conflict = 1'b1;
                end
            end
        end
    end

    assign o_wr_conflict = wr_conflict;

    genvar p;
    for (p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  byp_hit;
        logic [DATA_WIDTH-1:0] byp_data;
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic                  busy;

        assign addr = i_rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

        regfile_wr_select #(
            .NUM_WR    (NUM_WR),
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_byp (
            .match_addr_i(addr),
            .wr_en_i     (i_wr_en),
            .wr_addr_i   (i_wr_addr),
            .wr_data_i   (i_wr_data),
            .hit_o       (byp_hit),
            .data_o      (byp_data)
        );

        // Register 0 and out-of-range addresses never match, so they read as zero / not busy.
        always_comb begin
            valid = 1'b0;
            data  = '0;
            busy  = 1'b0;
            for (int k = 0; k < REG_DEPTH; k++) begin
                if (k != ZERO_REG && addr == ADDR_WIDTH'(k)) begin
                    valid = 1'b1;
                    data  = regs_q[k];
                    busy  = busy_q[k];
                end
            end
            if (BYPASS != 0 && valid && byp_hit) begin
                data = byp_data;
                busy = 1'b0;
            end
        end

        assign o_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
        assign o_rd_busy[p]                          = busy;
    end

endmodule
